i8254_rw_sequencer: RTL

- Bus-side read/write and control-word controller for the three 8254 counter channels.
- Decodes byte-wide host writes and reads. Stores each channel's control word.
- Sequences LSB/MSB count loading, counter-latch and status-latch commands, and the read-back command.
- Drives the per-channel configuration, load and hold strobes consumed by each channel's control logic and counting element.

---
 rtl/i8254_pkg.sv | 29 ++
 rtl/i8254_chan_port.sv | 175 +++++++++++++++++
 rtl/i8254_rw_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/i8254_pkg.sv
// Shared encodings for the 8254 bus-side read/write sequencer.
package i8254_pkg;

  // RW field of a control word
  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_BOTH  = 2'b11;

  // SC value that turns a control write into a read-back command
  localparam logic [1:0] SC_READBACK = 2'b11;
  // Address of the control-word register
  localparam logic [1:0] A_CTRL = 2'd3;

  // Status byte bit positions
  localparam int ST_OUT  = 7;
  localparam int ST_NULL = 6;

  // Control-word field slices
  localparam int CW_SC_HI = 7;
  localparam int CW_SC_LO = 6;
  localparam int CW_RW_HI = 5;
  localparam int CW_RW_LO = 4;

  // Read-back command: active-low count/status latch bits
  localparam int RB_NCOUNT  = 5;
  localparam int RB_NSTATUS = 4;

endpackage

// File: rtl/i8254_chan_port.sv
// Per-channel bus port: control word, LSB/MSB write and read pointers,
// count latch and (with READBACK_EN defined) status latch.
module i8254_chan_port
  import i8254_pkg::*;
#(
  parameter logic [7:0] RESET_CW = 8'h00
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        cw_wr,
  input  logic        latch_cmd,
  input  logic        st_latch_cmd,
  input  logic        cnt_wr,
  input  logic        cnt_rd,
  input  logic [7:0]  din,
  input  logic [7:0]  status_in,
  input  logic [15:0] cnt_value,
  output logic [7:0]  control_word,
  output logic        cw_written,
  output logic        cr_we,
  output logic [15:0] cr_data,
  output logic        first_byte_pending,
  output logic        ol_hold,
  output logic [7:0]  rd_byte
);

  logic [7:0]  cw_q, cw_d;
  logic        cw_written_q, cw_written_d;
  logic        cr_we_q, cr_we_d;
  logic [15:0] cr_data_q, cr_data_d;
  logic        wr_ptr_q, wr_ptr_d;
  logic [7:0]  lsb_q, lsb_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic        latched_q, latched_d;
  logic [15:0] latch_val_q, latch_val_d;
  logic        st_latched_q, st_latched_d;
  logic [7:0]  status_q, status_d;
  logic [1:0]  rw;
  logic [15:0] val;

  assign rw = cw_q[CW_RW_HI:CW_RW_LO];
  assign val = latched_q ? latch_val_q : cnt_value;

  // Byte presented on a read of this channel this cycle
  always_comb begin
    rd_byte = 8'h00;
    if (st_latched_q) begin
      rd_byte = status_q;
    end else begin
      case (rw)
        RW_LSB:  rd_byte = val[7:0];
        RW_MSB:  rd_byte = val[15:8];
        RW_BOTH: rd_byte = rd_ptr_q ? val[15:8] : val[7:0];
        default: rd_byte = 8'h00;
      endcase
    end
  end

  // Next-state for control word, pointers and latches
  always_comb begin
    cw_d         = cw_q;
    cw_written_d = 1'b0;
    cr_we_d      = 1'b0;
    cr_data_d    = 16'h0000;
    wr_ptr_d     = wr_ptr_q;
    lsb_d        = lsb_q;
    rd_ptr_d     = rd_ptr_q;
    latched_d    = latched_q;
    latch_val_d  = latch_val_q;
    st_latched_d = st_latched_q;
    status_d     = status_q;
    if (cw_wr) begin
      cw_d         = din;
      cw_written_d = 1'b1;
      wr_ptr_d     = 1'b0;
      rd_ptr_d     = 1'b0;
      latched_d    = 1'b0;
      st_latched_d = 1'b0;
    end else begin
      if (latch_cmd && !latched_q) begin
        latched_d   = 1'b1;
        latch_val_d = cnt_value;
      end
      if (st_latch_cmd && !st_latched_q) begin
        st_latched_d = 1'b1;
        status_d     = status_in;
      end
      if (cnt_wr) begin
        case (rw)
          RW_LSB: begin
            cr_we_d   = 1'b1;
            cr_data_d = {8'h00, din};
          end
          RW_MSB: begin
            cr_we_d   = 1'b1;
            cr_data_d = {din, 8'h00};
          end
          RW_BOTH: begin
            if (!wr_ptr_q) begin
              lsb_d    = din;
              wr_ptr_d = 1'b1;
            end else begin
              cr_we_d   = 1'b1;
              cr_data_d = {din, lsb_q};
              wr_ptr_d  = 1'b0;
            end
          end
          default: ;
        endcase
      end
      if (cnt_rd) begin
        if (st_latched_q) begin
          st_latched_d = 1'b0;
        end else if (rw == RW_BOTH) begin
          rd_ptr_d = ~rd_ptr_q;
          if (rd_ptr_q) latched_d = 1'b0;
        end else begin
          // single-byte formats (and an unprogrammed channel) finish in one read
          latched_d = 1'b0;
        end
      end
    end
  end

  // Channel state registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cw_q         <= RESET_CW;
      cw_written_q <= 1'b0;
      cr_we_q      <= 1'b0;
      cr_data_q    <= 16'h0000;
      wr_ptr_q     <= 1'b0;
      lsb_q        <= 8'h00;
      rd_ptr_q     <= 1'b0;
      latched_q    <= 1'b0;
      latch_val_q  <= 16'h0000;
    end else begin
      cw_q         <= cw_d;
      cw_written_q <= cw_written_d;
      cr_we_q      <= cr_we_d;
      cr_data_q    <= cr_data_d;
      wr_ptr_q     <= wr_ptr_d;
      lsb_q        <= lsb_d;
      rd_ptr_q     <= rd_ptr_d;
      latched_q    <= latched_d;
      latch_val_q  <= latch_val_d;
    end
  end

`ifdef READBACK_EN
  // Status latch registers, present only with read-back support
  always_ff @(posedge CLK) begin
    if (RESET) begin
      st_latched_q <= 1'b0;
      status_q     <= 8'h00;
    end else begin
      st_latched_q <= st_latched_d;
      status_q     <= status_d;
    end
  end
`else
  assign st_latched_q = 1'b0;
  assign status_q     = 8'h00;
  logic unused_status;
  assign unused_status = ^{st_latched_d, status_d, st_latch_cmd, status_in};
`endif

  assign control_word       = cw_q;
  assign cw_written         = cw_written_q;
  assign cr_we              = cr_we_q;
  assign cr_data            = cr_data_q;
  assign first_byte_pending = wr_ptr_q;
  assign ol_hold            = latched_q;

endmodule

// File: rtl/i8254_rw_sequencer.sv
// 8254 bus-side read/write and control-word sequencer: address decode,
// command decode and read-data muxing around per-channel ports.
// Optional macro READBACK_EN enables the read-back command and status latch.
module i8254_rw_sequencer
  import i8254_pkg::*;
#(
  parameter int         NUM_CNT  = 3,
  parameter logic [7:0] RESET_CW = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  cs,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [1:0]            a,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  rd_valid,
  input  logic [16*NUM_CNT-1:0] cnt_value,
  input  logic [NUM_CNT-1:0]    cnt_out,
  input  logic [NUM_CNT-1:0]    cnt_null,
  output logic [8*NUM_CNT-1:0]  control_word,
  output logic [NUM_CNT-1:0]    cw_written,
  output logic [NUM_CNT-1:0]    cr_we,
  output logic [15:0]           cr_data,
  output logic [NUM_CNT-1:0]    first_byte_pending,
  output logic [NUM_CNT-1:0]    ol_hold
);

`ifdef READBACK_EN
  localparam bit RB_ON = 1'b1;
`else
  localparam bit RB_ON = 1'b0;
`endif

  logic       acc_wr, acc_rd, ctrl_wr, rb_cmd;
  logic [1:0] sc, rw_f;
  logic [7:0]  rd_bytes   [NUM_CNT];
  logic [15:0] cr_data_ch [NUM_CNT];
  logic [7:0]  dout_q, dout_d;
  logic        rd_valid_q, rd_valid_d;

  // a simultaneous write wins; the read is dropped
  assign acc_wr  = cs && wr;
  assign acc_rd  = cs && rd && !wr;
  assign ctrl_wr = acc_wr && (a == A_CTRL);
  assign sc      = din[CW_SC_HI:CW_SC_LO];
  assign rw_f    = din[CW_RW_HI:CW_RW_LO];
  assign rb_cmd  = RB_ON && ctrl_wr && (sc == SC_READBACK);

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
    localparam logic [1:0] IDX = 2'(i);
    logic       sel_sc, rb_sel;
    logic [7:0] st;
    assign sel_sc = ctrl_wr && (sc == IDX);
    assign rb_sel = rb_cmd && din[i+1];
    assign st[ST_OUT]  = cnt_out[i];
    assign st[ST_NULL] = cnt_null[i];
    assign st[5:0]     = control_word[8*i +: 6];

    i8254_chan_port #(.RESET_CW(RESET_CW)) u_port (
      .CLK               (CLK),
      .RESET             (RESET),
      .cw_wr             (sel_sc && (rw_f != RW_LATCH)),
      .latch_cmd         ((sel_sc && (rw_f == RW_LATCH)) || (rb_sel && !din[RB_NCOUNT])),
      .st_latch_cmd      (rb_sel && !din[RB_NSTATUS]),
      .cnt_wr            (acc_wr && (a == IDX)),
      .cnt_rd            (acc_rd && (a == IDX)),
      .din               (din),
      .status_in         (st),
      .cnt_value         (cnt_value[16*i +: 16]),
      .control_word      (control_word[8*i +: 8]),
      .cw_written        (cw_written[i]),
      .cr_we             (cr_we[i]),
      .cr_data           (cr_data_ch[i]),
      .first_byte_pending(first_byte_pending[i]),
      .ol_hold           (ol_hold[i]),
      .rd_byte           (rd_bytes[i])
    );
  end

  // Only one channel can load per cycle; idle channels present zero
  always_comb begin
    cr_data = 16'h0000;
    for (int i = 0; i < NUM_CNT; i++) cr_data = cr_data | cr_data_ch[i];
  end

  // Read data select; control address and absent channels read as zero
  always_comb begin
    dout_d     = 8'h00;
    rd_valid_d = acc_rd;
    if (acc_rd) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (a == 2'(i)) dout_d = rd_bytes[i];
      end
    end
  end

  // Registered read port
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dout_q     <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      dout_q     <= dout_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign dout     = dout_q;
  assign rd_valid = rd_valid_q;

endmodule
